usb_tx_sequencer: RTL and testbench

Transmit packet sequencer for the USB host bitstream path. It accepts one packet request (token or handshake), then serialises SYNC and PID directly and the token address/endpoint field through the crc block, which appends CRC5. It waits for the CRC tail to drain, requests EOP from the line driver, and reports completion. It owns crc's recving and inb inputs and selects between the raw bit and crc's outb for the downstream bit stuffer and NRZI stage.

---
 rtl/usb_tx_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_sequencer.sv
// usb_tx_sequencer
//   Transmit packet sequencer for the USB host bitstream path. It accepts one
//   token or handshake request and then sends it in this order:
//     - SYNC and PID as raw bits on tx_bit;
//     - for tokens only, the 11-bit addr/endp field through the crc block,
//       which appends CRC5;
//     - after the CRC tail drains, EOP is requested from the line driver;
//     - completion is reported on pkt_done.
//
// Optional build macro: USB_TXSEQ_PID_CHECK_EN
//   When defined, only OUT/IN/SETUP/ACK/NAK/STALL PIDs are accepted. An
//   illegal PID is consumed with req_ready and pkt_err pulsed together, and
//   nothing is sent. When undefined, every PID is sent and pkt_err is tied 0.
//
// Parameters
//   SYNC_PATTERN : SYNC bits, sent bit0 first
//   FIELD_BITS   : token field length (addr[6:0] then endp[3:0], LSB first)
//
// Ports
//   clk, rst_L      : clock; asynchronous active-low reset
//   req_valid       : request present
//   req_pid         : PID of the request
//   req_addr        : device address (tokens only)
//   req_endp        : endpoint (tokens only)
//   req_ready       : one-cycle accept pulse; the request fields are latched
//   tx_bit          : raw bit during SYNC/PID
//   tx_sel_crc      : 1 selects crc outb downstream, 0 selects tx_bit
//   tx_active       : packet in progress (SYNC through EOP)
//   stuff_pause     : downstream stall; hold the current bit
//   crc_inb         : field bit fed to crc
//   crc_recving     : crc recving control
//   crc_pause_out   : stuff_pause forwarded to crc
//   crc_sending     : crc is still shifting out CRC bits
//   eop_req         : level request for EOP to the line driver
//   eop_done        : line driver has finished EOP
//   pkt_done        : one-cycle pulse, first IDLE cycle after EOP
//   pkt_err         : illegal-PID pulse (macro builds only)
module usb_tx_sequencer #(
  parameter logic [7:0]  SYNC_PATTERN = 8'h80,
  parameter int unsigned FIELD_BITS   = 11
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       req_valid,
  input  logic [3:0] req_pid,
  input  logic [6:0] req_addr,
  input  logic [3:0] req_endp,
  output logic       req_ready,
  output logic       tx_bit,
  output logic       tx_sel_crc,
  output logic       tx_active,
  input  logic       stuff_pause,
  output logic       crc_inb,
  output logic       crc_recving,
  output logic       crc_pause_out,
  input  logic       crc_sending,
  output logic       eop_req,
  input  logic       eop_done,
  output logic       pkt_done,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_FIELD,
    S_CRCWAIT,
    S_EOP
  } state_t;

  localparam logic [3:0] BYTE_LAST  = 4'd7;
  localparam logic [3:0] FIELD_LAST = 4'(FIELD_BITS - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              pid_q;
  logic [6:0]              addr_q;
  logic [3:0]              endp_q;
  logic                    pkt_done_q, pkt_done_d;
  logic                    latch_en;
  logic                    pid_illegal;
  logic                    is_token;
  logic [7:0]              pid_byte;
  logic [FIELD_BITS-1:0]   field;

  assign pid_byte      = {~pid_q, pid_q};
  assign field         = {endp_q, addr_q};
  assign is_token      = (pid_q[1:0] == 2'b01);
  assign crc_pause_out = stuff_pause;
  assign pkt_done      = pkt_done_q;

`ifdef USB_TXSEQ_PID_CHECK_EN
  always_comb begin
    pid_illegal = 1'b1;
    unique case (req_pid)
      4'b0001, 4'b1001, 4'b1101,
      4'b0010, 4'b1010, 4'b1110: pid_illegal = 1'b0;
      default:                   pid_illegal = 1'b1;
    endcase
  end
`else
  assign pid_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pid_q      <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pkt_done_q <= pkt_done_d;
      if (latch_en) begin
        pid_q  <= req_pid;
        addr_q <= req_addr;
        endp_q <= req_endp;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_en    = 1'b0;
    pkt_done_d  = 1'b0;
    req_ready   = 1'b0;
    pkt_err     = 1'b0;
    tx_bit      = 1'b0;
    tx_sel_crc  = 1'b0;
    tx_active   = 1'b1;
    crc_inb     = 1'b0;
    crc_recving = 1'b0;
    eop_req     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_active = 1'b0;
        // rst_L gates acceptance so req_ready stays 0 while reset is held;
        // pkt_done_q blocks a re-accept in the cycle that reports completion.
        if (rst_L && req_valid && !pkt_done_q) begin
          req_ready = 1'b1;
          if (pid_illegal) begin
            pkt_err = 1'b1;
          end else begin
            latch_en = 1'b1;
            state_d  = S_SYNC;
            cnt_d    = '0;
          end
        end
      end

      S_SYNC: begin
        tx_bit = SYNC_PATTERN[cnt_q[2:0]];
        if (!stuff_pause) begin
          if (cnt_q == BYTE_LAST) begin
            state_d = S_PID;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_PID: begin
        tx_bit = pid_byte[cnt_q[2:0]];
        // crc must already be in CALCCRC when the first field bit arrives,
        // so recving is raised one bit early while the mux still selects tx_bit.
        if (is_token && cnt_q == BYTE_LAST) begin
          crc_recving = 1'b1;
        end
        if (!stuff_pause) begin
          if (cnt_q == BYTE_LAST) begin
            state_d = is_token ? S_FIELD : S_EOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_FIELD: begin
        crc_recving = 1'b1;
        tx_sel_crc  = 1'b1;
        crc_inb     = field[cnt_q];
        if (!stuff_pause) begin
          if (cnt_q == FIELD_LAST) begin
            state_d = S_CRCWAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      S_CRCWAIT: begin
        tx_sel_crc = 1'b1;
        if (!crc_sending) begin
          state_d = S_EOP;
          cnt_d   = '0;
        end
      end

      S_EOP: begin
        eop_req = 1'b1;
        if (eop_done) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          pkt_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Bench for usb_tx_sequencer. A slot-based reference model expands each
// request into the expected per-cycle output record: accept, 8 SYNC bits,
// 8 PID bits, 11 field bits for tokens, each bit repeated while stalled,
// then CRC drain, EOP and the completion pulse.
module tb_usb_tx_sequencer;

  logic       clk;
  logic       rst_L;
  logic       req_valid;
  logic [3:0] req_pid;
  logic [6:0] req_addr;
  logic [3:0] req_endp;
  logic       req_ready;
  logic       tx_bit;
  logic       tx_sel_crc;
  logic       tx_active;
  logic       stuff_pause;
  logic       crc_inb;
  logic       crc_recving;
  logic       crc_pause_out;
  logic       crc_sending;
  logic       eop_req;
  logic       eop_done;
  logic       pkt_done;
  logic       pkt_err;

  int checks = 0;
  int errors = 0;

  // Record layout: {ready, err, active, tx_bit, sel, recv, inb, eop, done, pause}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic       stall_q[$];
  int         stall_at[32];
  int         drain_n;
  int         eop_n;
  bit         hold_v;

  usb_tx_sequencer #(.SYNC_PATTERN(8'h80), .FIELD_BITS(11)) dut (
    .clk          (clk),
    .rst_L        (rst_L),
    .req_valid    (req_valid),
    .req_pid      (req_pid),
    .req_addr     (req_addr),
    .req_endp     (req_endp),
    .req_ready    (req_ready),
    .tx_bit       (tx_bit),
    .tx_sel_crc   (tx_sel_crc),
    .tx_active    (tx_active),
    .stuff_pause  (stuff_pause),
    .crc_inb      (crc_inb),
    .crc_recving  (crc_recving),
    .crc_pause_out(crc_pause_out),
    .crc_sending  (crc_sending),
    .eop_req      (eop_req),
    .eop_done     (eop_done),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] observe();
    return {req_ready, pkt_err, tx_active, tx_bit, tx_sel_crc, crc_recving,
            crc_inb, eop_req, pkt_done, crc_pause_out};
  endfunction

  function automatic logic [9:0] rec(input logic rdy, input logic err, input logic act,
                                     input logic b, input logic sel, input logic rcv,
                                     input logic inb, input logic eop, input logic done,
                                     input logic pause);
    return {rdy, err, act, b, sel, rcv, inb, eop, done, pause};
  endfunction

  function automatic void clear_stalls();
    for (int i = 0; i < 32; i++) stall_at[i] = 0;
  endfunction

  function automatic int first_idx(input int bitpos);
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][bitpos]) return i;
    return -1;
  endfunction

  // One clock cycle: inputs already set; sample mid-cycle, then step past the edge.
  task automatic cyc(input logic [9:0] e);
    exp_q.push_back(e);
    stall_q.push_back(stuff_pause);
    @(negedge clk);
    obs_q.push_back(observe());
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    crc_sending = 1'($urandom_range(0, 1));
    eop_done    = 1'($urandom_range(0, 1));
  endtask

  // Drives one request and fills exp_q/obs_q; stall_at, drain_n, eop_n and
  // hold_v shape the stimulus.
  task automatic drive_packet(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp);
    logic [7:0]  sync_v;
    logic [7:0]  pid_v;
    logic [10:0] fld;
    bit          token;
    bit          illegal;
    int          nslots;
    logic        b, inb;
    exp_q.delete();
    obs_q.delete();
    stall_q.delete();
    sync_v  = 8'h80;
    pid_v   = {~pid, pid};
    fld     = {endp, addr};
    illegal = 1'b0;
`ifdef USB_TXSEQ_PID_CHECK_EN
    illegal = !(pid inside {4'b0001, 4'b1001, 4'b1101, 4'b0010, 4'b1010, 4'b1110});
`endif
    token   = (pid[1:0] == 2'b01) && !illegal;

    req_valid   = 1'b1;
    req_pid     = pid;
    req_addr    = addr;
    req_endp    = endp;
    stuff_pause = 1'($urandom_range(0, 1));
    noise();
    cyc(rec(1, illegal, 0, 0, 0, 0, 0, 0, 0, stuff_pause));

    req_valid = illegal ? 1'b0 : hold_v;
    req_pid   = 4'($urandom);
    req_addr  = 7'($urandom);
    req_endp  = 4'($urandom);
    if (illegal) begin
      stuff_pause = 1'b0;
      cyc(rec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      return;
    end

    nslots = token ? 27 : 16;
    for (int s = 0; s < nslots; s++) begin
      if (s < 8)       b = sync_v[s];
      else if (s < 16) b = pid_v[s-8];
      else             b = 1'b0;
      inb = (s >= 16) ? fld[s-16] : 1'b0;
      for (int k = 0; k < stall_at[s]; k++) begin
        stuff_pause = 1'b1;
        noise();
        cyc(rec(0, 0, 1, b, s >= 16, token && s >= 15, inb, 0, 0, 1));
      end
      stuff_pause = 1'b0;
      noise();
      cyc(rec(0, 0, 1, b, s >= 16, token && s >= 15, inb, 0, 0, 0));
    end

    eop_done = 1'b0;
    if (token) begin
      for (int k = 0; k <= drain_n; k++) begin
        crc_sending = (k < drain_n);
        stuff_pause = 1'($urandom_range(0, 1));
        cyc(rec(0, 0, 1, 0, 1, 0, 0, 0, 0, stuff_pause));
      end
    end

    for (int k = 0; k <= eop_n; k++) begin
      eop_done    = (k == eop_n);
      crc_sending = 1'($urandom_range(0, 1));
      stuff_pause = 1'($urandom_range(0, 1));
      cyc(rec(0, 0, 1, 0, 0, 0, 0, 1, 0, stuff_pause));
    end

    req_valid   = hold_v;
    stuff_pause = 1'($urandom_range(0, 1));
    noise();
    cyc(rec(0, 0, 0, 0, 0, 0, 0, 0, 1, stuff_pause));
    if (!hold_v) req_valid = 1'b0;
    stuff_pause = 1'b0;
    crc_sending = 1'b0;
    eop_done    = 1'b0;
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    req_valid = 1'b1;
    req_pid = 4'b0010;
    stuff_pause = 1'b0;
    crc_sending = 1'b1;
    eop_done = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (observe() !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", observe(), 10'b0);
    end
    req_valid = 1'b0;
    crc_sending = 1'b0;
    eop_done = 1'b0;
    @(posedge clk);
    #1 rst_L = 1'b1;
    @(negedge clk);
    checks++;
    if (observe() !== 10'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected %b", observe(), 10'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ack();
    logic [15:0] seq;
    int e, last_eop, d;
    clear_stalls();
    drain_n = 0;
    eop_n = 2;
    hold_v = 1'b0;
    drive_packet(4'b0010, 7'($urandom), 4'($urandom));
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ack_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 16; i++) seq[i] = obs_q[i+1][6];
    checks++;
    if (seq !== 16'b1101_0010_1000_0000) begin
      errors++;
      $display("FAIL ack_bitstream: got %b expected %b", seq, 16'b1101_0010_1000_0000);
    end
    e = first_idx(2);
    checks++;
    if (e !== 17) begin
      errors++;
      $display("FAIL ack_eop_latency: got cycle %0d expected 17", e);
    end
    checks++;
    if (first_idx(4) !== -1) begin
      errors++;
      $display("FAIL ack_no_recving: got recving at cycle %0d expected never", first_idx(4));
    end
    last_eop = e + eop_n;
    d = first_idx(1);
    checks++;
    if (d !== last_eop + 1) begin
      errors++;
      $display("FAIL ack_done_timing: got cycle %0d expected %0d", d, last_eop + 1);
    end
  endtask

  task automatic test_out_token();
    logic [4:0]  crc;
    logic [10:0] got_fld;
    int nbits, nrecv;
    clear_stalls();
    drain_n = 5;
    eop_n = 1;
    hold_v = 1'b0;
    drive_packet(4'b0001, 7'h15, 4'hE);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL out_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    crc = 5'h1F;
    nbits = 0;
    nrecv = 0;
    got_fld = '0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][4]) nrecv++;
      if (obs_q[i][4] && obs_q[i][5] && !stall_q[i]) begin
        if (nbits < 11) got_fld[nbits] = obs_q[i][3];
        nbits++;
        if (crc[4] ^ obs_q[i][3]) crc = {crc[3:0], 1'b0} ^ 5'h05;
        else                      crc = {crc[3:0], 1'b0};
      end
    end
    crc = ~crc;
    checks++;
    if (nrecv !== 12) begin
      errors++;
      $display("FAIL out_recving_len: got %0d expected 12", nrecv);
    end
    checks++;
    if (nbits !== 11 || got_fld !== {4'hE, 7'h15}) begin
      errors++;
      $display("FAIL out_field: got %0d bits %h expected 11 bits %h", nbits, got_fld,
               {4'hE, 7'h15});
    end
    checks++;
    if (crc !== 5'h17) begin
      errors++;
      $display("FAIL out_crc5: got %h expected 17", crc);
    end
  endtask

  task automatic test_stall();
    int e0, e1;
    logic [6:0] a;
    logic [3:0] ep;
    a = 7'($urandom);
    ep = 4'($urandom);
    clear_stalls();
    drain_n = 5;
    eop_n = 0;
    hold_v = 1'b0;
    drive_packet(4'b1001, a, ep);
    e0 = first_idx(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL in_nostall_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    stall_at[3] = 2;
    stall_at[13] = 2;
    drive_packet(4'b1001, a, ep);
    e1 = first_idx(2);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL in_stall_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (e1 !== e0 + 4) begin
      errors++;
      $display("FAIL stall_eop_delay: got %0d expected %0d", e1, e0 + 4);
    end
    clear_stalls();
  endtask

  task automatic test_back_to_back();
    clear_stalls();
    drain_n = 3;
    eop_n = 1;
    hold_v = 1'b1;
    drive_packet(4'b0001, 7'($urandom), 4'($urandom));
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_first_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    hold_v = 1'b0;
    drive_packet(4'b1010, 7'($urandom), 4'($urandom));
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_second_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] fld;
    fld = {4'h6, 7'h2B};
    req_valid = 1'b1;
    req_pid = 4'b0001;
    req_addr = 7'h2B;
    req_endp = 4'h6;
    stuff_pause = 1'b0;
    crc_sending = 1'b0;
    eop_done = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({crc_recving, tx_sel_crc, crc_inb} !== {1'b1, 1'b1, fld[4]}) begin
      errors++;
      $display("FAIL mid_field_bit4: got %b expected %b", {crc_recving, tx_sel_crc, crc_inb},
               {1'b1, 1'b1, fld[4]});
    end
    #2 rst_L = 1'b0;
    #1;
    checks++;
    if (observe() !== 10'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected %b", observe(), 10'b0);
    end
    @(posedge clk);
    #1 rst_L = 1'b1;
    clear_stalls();
    drain_n = 0;
    eop_n = 1;
    hold_v = 1'b0;
    drive_packet(4'b0010, 7'($urandom), 4'($urandom));
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL post_reset_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef USB_TXSEQ_PID_CHECK_EN
  task automatic test_pid_check();
    clear_stalls();
    drain_n = 0;
    eop_n = 0;
    hold_v = 1'b0;
    drive_packet(4'b0000, 7'($urandom), 4'($urandom));
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pidchk_cycle%0d: got %b expected %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first_idx(7) !== -1) begin
      errors++;
      $display("FAIL pidchk_active: got active at cycle %0d expected never", first_idx(7));
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      clear_stalls();
      for (int s = 0; s < 27; s++) begin
        if ($urandom_range(0, 5) == 0) stall_at[s] = int'($urandom_range(1, 2));
      end
      drain_n = int'($urandom_range(0, 6));
      eop_n = int'($urandom_range(0, 4));
      hold_v = 1'($urandom_range(0, 1));
      drive_packet(4'($urandom), 7'($urandom), 4'($urandom));
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_cycle%0d: got %b expected %b", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
    hold_v = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    rst_L = 1'b0;
    req_valid = 1'b0;
    req_pid = '0;
    req_addr = '0;
    req_endp = '0;
    stuff_pause = 1'b0;
    crc_sending = 1'b0;
    eop_done = 1'b0;
    clear_stalls();
    test_reset();
    test_ack();
    test_out_token();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef USB_TXSEQ_PID_CHECK_EN
    test_pid_check();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
